// File: rtl/alu_io_pkg.sv
// Shared definitions for the ALU pin-I/O blocks: byte width, byte-count
// derivation, serializer state encoding and result flag bit positions.
// Optional feature macro: FLAGS_BYTE_EN (appends a flags trailer byte).
package alu_io_pkg;

  localparam int BYTE_W = 8;

  // Bit positions inside the 4-bit result flag nibble
  localparam int FLAG_ZERO = 0;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 2;
  localparam int FLAG_NAN  = 3;

  // Number of bytes presented per result word
  function automatic int nbytes_for(input int word_w);
`ifdef FLAGS_BYTE_EN
    return word_w / BYTE_W + 1;
`else
    return word_w / BYTE_W;
`endif
  endfunction

  localparam int NBYTES = nbytes_for(32);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/alu_result_serializer_strobe_sync.sv
// Brings the asynchronous host read strobe into the clk domain and turns
// each rising edge into a single-cycle advance pulse.
module strobe_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic strobe,
  output logic adv_pulse
);

  logic sync_p0;
  logic sync_p1;
  logic prev_p2;

  // Two-flop synchronizer followed by a previous-value flop for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      prev_p2 <= 1'b0;
    end else begin
      sync_p0 <= strobe;
      sync_p1 <= sync_p0;
      prev_p2 <= sync_p1;
    end
  end

  // Built only from flops, so a held-high strobe yields exactly one pulse
  assign adv_pulse = sync_p1 & ~prev_p2;

endmodule

// File: rtl/alu_result_serializer.sv
// Byte-serial readout of the ALU result word, MSB first, advanced by a host
// strobe. Optional feature macro: FLAGS_BYTE_EN appends {4'b0, res_flags}
// as a trailer byte after the LSB data byte.
module alu_result_serializer
  import alu_io_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [WORD_W-1:0] res_data,
  input  logic [3:0]        res_flags,
  input  logic              rd_strobe,
  output logic [BYTE_W-1:0] byte_out,
  output logic              byte_valid,
  output logic              byte_last,
  output logic [2:0]        byte_idx
);

  localparam int NB   = nbytes_for(WORD_W);
  localparam int SR_W = NB * BYTE_W;

  ser_state_t        state;
  logic [SR_W-1:0]   shreg;
  logic [SR_W-1:0]   cap_word;
  logic              adv_pulse;

`ifdef FLAGS_BYTE_EN
  assign cap_word = {res_data, 4'b0000, res_flags};
`else
  logic unused_flags;
  assign unused_flags = ^res_flags;
  assign cap_word     = res_data;
`endif

  strobe_sync u_strobe_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .strobe    (rd_strobe),
    .adv_pulse (adv_pulse)
  );

  // Capture / advance FSM; the shift register is cleared on return to IDLE
  // so byte_out reads 0 there without any output gating logic
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      shreg     <= '0;
      byte_idx  <= 3'd0;
      byte_last <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (res_valid) begin
            shreg     <= cap_word;
            byte_idx  <= 3'd0;
            byte_last <= (NB == 1);
            state     <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (adv_pulse) begin
            if (byte_last) begin
              shreg     <= '0;
              byte_idx  <= 3'd0;
              byte_last <= 1'b0;
              state     <= S_IDLE;
            end else begin
              shreg     <= {shreg[SR_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
              byte_idx  <= byte_idx + 3'd1;
              byte_last <= (byte_idx == 3'(NB - 2));
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign res_ready  = (state == S_IDLE);
  assign byte_valid = (state == S_PRESENT);
  assign byte_out   = shreg[SR_W-1 -: BYTE_W];

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed testbench for alu_result_serializer (default and FLAGS_BYTE_EN builds).
module tb_alu_result_serializer;

`ifdef FLAGS_BYTE_EN
  localparam int TB_NB = 5;
`else
  localparam int TB_NB = 4;
`endif

  logic        clk;
  logic        rst_n;
  logic        res_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [3:0]  res_flags;
  logic        rd_strobe;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_last;
  logic [2:0]  byte_idx;

  int checks = 0;
  int passes = 0;

  alu_result_serializer #(.WORD_W(32), .BYTE_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_flags  (res_flags),
    .rd_strobe  (rd_strobe),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_last  (byte_last),
    .byte_idx   (byte_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers: all called and returning at posedge+1
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] w, input logic [3:0] f);
    res_valid = 1'b1;
    res_data  = w;
    res_flags = f;
    step(1);
    res_valid = 1'b0;
  endtask

  task automatic strobe_pulse();
    rd_strobe = 1'b1;
    step(4);
    rd_strobe = 1'b0;
    step(4);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; res_valid = 1'b0; res_data = '0; res_flags = '0; rd_strobe = 1'b0;
    step(2);
    checks++; if (res_ready !== 1'b1) $display("FAIL reset_ready got %b want 1", res_ready); else passes++;
    checks++; if (byte_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", byte_valid); else passes++;
    checks++; if (byte_out !== 8'h00) $display("FAIL reset_byte got %h want 00", byte_out); else passes++;
    checks++; if ({byte_last, byte_idx} !== 4'b0) $display("FAIL reset_last_idx got %b want 0000", {byte_last, byte_idx}); else passes++;
    rst_n = 1'b1;
    step(2);
  endtask

  task automatic test_basic();
    logic [7:0] exp [5] = '{8'h3F, 8'h80, 8'h00, 8'h00, 8'h00};
    send_word(32'h3F80_0000, 4'h0);
    for (int i = 0; i < TB_NB; i++) begin
      if (i > 0) strobe_pulse();
      checks++;
      if ({byte_valid, res_ready, byte_out, byte_idx, byte_last} !== {1'b1, 1'b0, exp[i], 3'(i), (i == TB_NB - 1)})
        $display("FAIL basic_byte%0d got v=%b r=%b b=%h i=%0d l=%b want v=1 r=0 b=%h i=%0d l=%b",
                 i, byte_valid, res_ready, byte_out, byte_idx, byte_last, exp[i], i, (i == TB_NB - 1));
      else passes++;
    end
    strobe_pulse();
    checks++;
    if ({res_ready, byte_valid, byte_out} !== {1'b1, 1'b0, 8'h00})
      $display("FAIL basic_idle got r=%b v=%b b=%h want r=1 v=0 b=00", res_ready, byte_valid, byte_out);
    else passes++;
  endtask

  task automatic test_flags();
`ifdef FLAGS_BYTE_EN
    logic [7:0] exp [5] = '{8'hC0, 8'h49, 8'h0F, 8'hDB, 8'h05};
    send_word(32'hC049_0FDB, 4'b0101);
`else
    logic [7:0] exp [5] = '{8'hC0, 8'h49, 8'h0F, 8'hDB, 8'h00};
    send_word(32'hC049_0FDB, 4'b1111);
`endif
    for (int i = 0; i < TB_NB; i++) begin
      if (i > 0) strobe_pulse();
      checks++;
      if ({byte_out, byte_idx, byte_last} !== {exp[i], 3'(i), (i == TB_NB - 1)})
        $display("FAIL flags_byte%0d got b=%h i=%0d l=%b want b=%h i=%0d l=%b",
                 i, byte_out, byte_idx, byte_last, exp[i], i, (i == TB_NB - 1));
      else passes++;
    end
    strobe_pulse();
    checks++; if (res_ready !== 1'b1) $display("FAIL flags_idle got %b want 1", res_ready); else passes++;
  endtask

  task automatic test_held_strobe();
    send_word(32'hA1B2_C3D4, 4'h0);
    rd_strobe = 1'b1;
    step(1); // edge N samples high
    checks++; if ({byte_out, byte_idx} !== {8'hA1, 3'd0}) $display("FAIL held_edgeN got %h/%0d want a1/0", byte_out, byte_idx); else passes++;
    step(1); // N+1
    checks++; if ({byte_out, byte_idx} !== {8'hA1, 3'd0}) $display("FAIL held_edgeN1 got %h/%0d want a1/0", byte_out, byte_idx); else passes++;
    step(1); // N+2
    checks++; if ({byte_out, byte_idx} !== {8'hB2, 3'd1}) $display("FAIL held_edgeN2 got %h/%0d want b2/1", byte_out, byte_idx); else passes++;
    step(17);
    checks++; if ({byte_out, byte_idx} !== {8'hB2, 3'd1}) $display("FAIL held_single got %h/%0d want b2/1", byte_out, byte_idx); else passes++;
    rd_strobe = 1'b0;
    step(4);
    for (int i = 1; i < TB_NB; i++) strobe_pulse();
    checks++; if (res_ready !== 1'b1) $display("FAIL held_drain got %b want 1", res_ready); else passes++;
  endtask

  task automatic test_reset_mid();
    send_word(32'h1234_5678, 4'h0);
    strobe_pulse();
    strobe_pulse();
    checks++; if ({byte_out, byte_idx} !== {8'h56, 3'd2}) $display("FAIL rstmid_pre got %h/%0d want 56/2", byte_out, byte_idx); else passes++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({res_ready, byte_valid, byte_out, byte_idx, byte_last} !== {1'b1, 1'b0, 8'h00, 3'd0, 1'b0})
      $display("FAIL rstmid_async got r=%b v=%b b=%h i=%0d l=%b want r=1 v=0 b=00 i=0 l=0",
               res_ready, byte_valid, byte_out, byte_idx, byte_last);
    else passes++;
    step(1);
    rst_n = 1'b1;
    step(1);
    send_word(32'hCAFE_F00D, 4'h0);
    checks++; if ({byte_valid, byte_out, byte_idx} !== {1'b1, 8'hCA, 3'd0}) $display("FAIL rstmid_next got v=%b %h/%0d want 1 ca/0", byte_valid, byte_out, byte_idx); else passes++;
    for (int i = 1; i < TB_NB; i++) strobe_pulse();
    checks++; if (byte_out !== 8'h0D && TB_NB == 4) $display("FAIL rstmid_lsb got %h want 0d", byte_out); else passes++;
    strobe_pulse();
  endtask

  task automatic test_back_to_back();
    send_word(32'h1122_3344, 4'h0);
    res_valid = 1'b1;
    res_data  = 32'hDEAD_BEEF;
    step(3);
    checks++; if ({res_ready, byte_out} !== {1'b0, 8'h11}) $display("FAIL b2b_hold got r=%b b=%h want r=0 b=11", res_ready, byte_out); else passes++;
    for (int i = 1; i < TB_NB; i++) strobe_pulse();
    checks++; if ({byte_last, byte_out} !== {1'b1, (TB_NB == 4) ? 8'h44 : 8'h00}) $display("FAIL b2b_lastbyte got l=%b b=%h", byte_last, byte_out); else passes++;
    rd_strobe = 1'b1;
    step(3); // N+2: final advance, back to IDLE, no capture yet
    checks++; if ({res_ready, byte_valid} !== 2'b10) $display("FAIL b2b_idle got r=%b v=%b want r=1 v=0", res_ready, byte_valid); else passes++;
    step(1); // N+3: held word captured
    checks++; if ({byte_valid, byte_out, byte_idx} !== {1'b1, 8'hDE, 3'd0}) $display("FAIL b2b_capture got v=%b %h/%0d want 1 de/0", byte_valid, byte_out, byte_idx); else passes++;
    res_valid = 1'b0;
    step(1);
    rd_strobe = 1'b0;
    step(4);
    strobe_pulse();
    checks++; if ({byte_out, byte_idx} !== {8'hAD, 3'd1}) $display("FAIL b2b_second got %h/%0d want ad/1", byte_out, byte_idx); else passes++;
    for (int i = 2; i < TB_NB; i++) strobe_pulse();
    strobe_pulse();
    checks++; if (res_ready !== 1'b1) $display("FAIL b2b_drain got %b want 1", res_ready); else passes++;
  endtask

  task automatic test_idle_strobe();
    strobe_pulse();
    strobe_pulse();
    step(4);
    checks++; if ({byte_valid, byte_out, byte_idx} !== {1'b0, 8'h00, 3'd0}) $display("FAIL idle_strobe got v=%b %h/%0d want 0 00/0", byte_valid, byte_out, byte_idx); else passes++;
    send_word(32'h55AA_66BB, 4'h0);
    step(6);
    checks++; if ({byte_valid, byte_out, byte_idx} !== {1'b1, 8'h55, 3'd0}) $display("FAIL idle_nospur got v=%b %h/%0d want 1 55/0", byte_valid, byte_out, byte_idx); else passes++;
    for (int i = 0; i < TB_NB; i++) strobe_pulse();
    checks++; if (res_ready !== 1'b1) $display("FAIL idle_drain got %b want 1", res_ready); else passes++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_flags();
    test_held_strobe();
    test_reset_mid();
    test_back_to_back();
    test_idle_strobe();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
